// File: rtl/prm_scan_pkg.sv
// Shared types and default sizes for the PRM edge-scan controller and its accumulator.
package prm_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_e;

  localparam int PRM_CODE_W    = 15;
  localparam int PRM_NUM_EDGES = 16;
  localparam int PRM_CNT_W     = 16;

endpackage

// File: rtl/prm_edge_scan_ctrl_if.sv
// Scan control, obstacle stream, checker bank and result handshake of the edge-scan controller.
interface prm_edge_scan_ctrl_if #(
  parameter int NUM_EDGES = 16,
  parameter int CODE_W    = 15,
  parameter int CNT_W     = 16
);
  logic                 start;
  logic                 busy;
  logic                 obs_valid;
  logic                 obs_ready;
  logic [CODE_W-1:0]    obs_code;
  logic                 obs_last;
  logic [CODE_W-1:0]    chk_code;
  logic [NUM_EDGES-1:0] chk_mask;
  logic                 res_valid;
  logic                 res_ready;
  logic [NUM_EDGES-1:0] res_blocked;
  logic [CNT_W-1:0]     res_count;

  modport master (
    output start, obs_valid, obs_code, obs_last, chk_mask, res_ready,
    input  busy, obs_ready, chk_code, res_valid, res_blocked, res_count
  );

  modport slave (
    input  start, obs_valid, obs_code, obs_last, chk_mask, res_ready,
    output busy, obs_ready, chk_code, res_valid, res_blocked, res_count
  );
endinterface

// File: rtl/prm_scan_accum.sv
// Checker input register, one-deep stage flag, blocked-edge OR accumulator and saturating code counter.
module prm_scan_accum
  import prm_scan_pkg::*;
#(
  parameter int NUM_EDGES = PRM_NUM_EDGES,
  parameter int CODE_W    = PRM_CODE_W,
  parameter int CNT_W     = PRM_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 take,
  input  logic [CODE_W-1:0]    code,
  input  logic                 last,
  input  logic [NUM_EDGES-1:0] chk_mask,
  output logic [CODE_W-1:0]    chk_code,
  output logic                 stage_v,
  output logic                 stage_last,
  output logic [NUM_EDGES-1:0] blocked,
  output logic [CNT_W-1:0]     count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      chk_code   <= '0;
      stage_v    <= 1'b0;
      stage_last <= 1'b0;
      blocked    <= '0;
      count      <= '0;
    end else begin
      // chk_mask reflects the code registered on the previous edge
      if (clr) begin
        blocked <= '0;
      end else if (stage_v) begin
        blocked <= blocked | chk_mask;
      end

      if (clr) begin
        count <= '0;
      end else if (take && count != {CNT_W{1'b1}}) begin
        count <= count + 1'b1;
      end

      if (take) begin
        chk_code   <= code;
        stage_v    <= 1'b1;
        stage_last <= last;
      end else begin
        stage_v    <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/prm_edge_scan_ctrl.sv
// Streams obstacle codes through the external edge-checker bank and returns one blocked-edge mask per scan.
// Optional PRM_EARLY_EXIT_EN: once every edge is blocked, remaining codes are swallowed without staging.
module prm_edge_scan_ctrl
  import prm_scan_pkg::*;
#(
  parameter int NUM_EDGES = PRM_NUM_EDGES,
  parameter int CODE_W    = PRM_CODE_W,
  parameter int CNT_W     = PRM_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  prm_edge_scan_ctrl_if.slave    bus
);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] SCAN  = ST_SCAN;
  localparam logic [1:0] DRAIN = ST_DRAIN;
  localparam logic [1:0] DONE  = ST_DONE;

  logic [1:0]           state;
  logic                 obs_ready;
  logic                 hs;
  logic                 take;
  logic                 discard;
  logic                 clr;
  logic                 stage_v;
  logic                 stage_last;
  logic [NUM_EDGES-1:0] blocked;

  assign obs_ready = (state == SCAN);
  assign hs        = bus.obs_valid & obs_ready;
  assign clr       = (state == IDLE) & bus.start;

`ifdef PRM_EARLY_EXIT_EN
  // Include the mask still in the stage so the code right after the last missing edge is dropped.
  assign discard = &(blocked | (stage_v ? bus.chk_mask : '0));
`else
  assign discard = 1'b0;
`endif

  assign take = hs & ~discard;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.start) state <= SCAN;
        SCAN:    if (hs && bus.obs_last) state <= DRAIN;
        // A staged code here is the stream tail; an empty stage means the tail was discarded.
        DRAIN:   if (!stage_v || stage_last) state <= DONE;
        DONE:    if (bus.res_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  prm_scan_accum #(
    .NUM_EDGES (NUM_EDGES),
    .CODE_W    (CODE_W),
    .CNT_W     (CNT_W)
  ) u_accum (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .take       (take),
    .code       (bus.obs_code),
    .last       (bus.obs_last),
    .chk_mask   (bus.chk_mask),
    .chk_code   (bus.chk_code),
    .stage_v    (stage_v),
    .stage_last (stage_last),
    .blocked    (blocked),
    .count      (bus.res_count)
  );

  assign bus.busy        = (state != IDLE);
  assign bus.obs_ready   = obs_ready;
  assign bus.res_valid   = (state == DONE);
  assign bus.res_blocked = blocked;

endmodule
